cla_sum_pipe: RTL and testbench
===============================

# cla_sum_pipe

Two-stage pipelined carry-lookahead adder with valid/ready handshakes on input and output. It is the consuming end of the group propagate/generate carry network. Stage 1 forms per-bit and per-block propagate/generate terms. Stage 2 resolves the inter-block carries by lookahead, then produces the sum and carry-out. It sits between the partial-product reduction of the array multiplier and its result register, and is also used as the mantissa/log adder in the approximate log multipliers.

## Interface
- WIDTH, 16, operand and sum width; must be a multiple of BLK, range 8..64
- BLK, 4, lookahead block width in bits; blocks = WIDTH/BLK
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  stage 1 can accept this cycle
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  a+b+cin, low WIDTH bits
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow; present only with CLA_SUM_OVF_EN

## Operation
- Reset (asynchronous, rst_n low): s1_valid=0, out_valid=0, sum=0, cout=0, ovf=0, and all stage-1 registers=0. in_ready reads 1 whenever rst_n is high and both stages are empty.
- Enables:
  - s2_en = !out_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en (combinational from out_ready).
- Stage 1, captured on in_valid & in_ready:
  - p[i]=a[i]^b[i], g[i]=a[i]&b[i]
  - Block k: P_k = AND of p over the block. G_k = g[top] | p[top]&g[top-1] | ... | (p[top..1] AND) & g[bottom].
  - cin and the operand sign bits are registered alongside.
  - s1_valid <= in_valid when s1_en.
- Stage 2, captured when s2_en:
  - Block carries: c_0=cin, c_{k+1}=G_k | P_k&c_k. Flattened sum-of-products lookahead, no ripple across blocks.
  - Bit carries inside block k ripple from c_k using the registered p/g.
  - sum[i]=p[i]^carry[i]. cout=c_{blocks}.
  - out_valid <= s1_valid.
  - sum, cout and ovf hold their value while out_valid & !out_ready.
- Stage 1 data registers update only on a handshake. Bubbles never overwrite valid data.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Latency is 2 cycles: data accepted at edge N appears on sum/out_valid after edge N+1, and is usable in cycle N+2 without backpressure.
- Throughput is 1 result/cycle while out_ready=1.
- Backpressure:
  - With out_ready=0 and both stages full, in_ready=0 in the same cycle.
  - When out_ready rises, in_ready rises combinationally and the pipe advances on the next edge. No data is lost or duplicated.
- Simultaneous events:
  - Output consumed and new input accepted in the same cycle: both stages advance.
  - Stage 1 empty and output stalled: one more input is accepted, so at most 2 items are in flight.
- Reset mid-operation: in-flight items are discarded, and outputs return to reset values immediately and asynchronously. Release of rst_n is synchronised externally.
- Combinational path out_ready -> in_ready exists. No combinational path from a, b or cin to any output.

## Configuration
- CLA_SUM_OVF_EN defined:
  - The ovf port exists.
  - ovf = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]), computed in stage 2 from the registered sign bits.
  - Reset value is 0; ovf holds with sum.
- CLA_SUM_OVF_EN undefined: the ovf port and the sign-bit registers are absent; all other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 with in_valid=1, then release -> out_valid=0, sum=0, cout=0 throughout reset. The first accepted operand appears 2 cycles after its acceptance edge.
- Full carry chain: WIDTH=16, a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 after 2 cycles. a=0x0F0F, b=0xF0F0, cin=1 -> same result, exercising P_k propagation through all blocks.
- Streaming: 1000 random (a, b, cin) pairs with out_ready=1 -> one result per cycle, in order, matching a+b+cin on 17 bits.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0, sum stable. Release -> the two held results drain in order and in_ready=1 in the release cycle.
- Random backpressure: in_valid and out_ready each 50% random over 2000 cycles -> the scoreboard shows no loss, duplication or reordering.
- With CLA_SUM_OVF_EN: 0x7FFF+0x0001 -> ovf=1, sum=0x8000, cout=0. 0x8000+0x8000 -> ovf=1, sum=0x0000, cout=1. 0x7FFF+0x8000 -> ovf=0.

Source files
------------

// File: rtl/cla_sum_pipe_if.sv
// cla_sum_pipe_if: handshake and data bundle for the pipelined CLA adder.
//   in_valid/in_ready   : operand handshake (producer -> adder)
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake (adder -> consumer)
//   sum, cout           : low WIDTH bits of a+b+cin and carry out
//   ovf                 : signed overflow, only when CLA_SUM_OVF_EN is defined
// Modports: master = operand producer / result consumer, slave = adder.
interface cla_sum_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CLA_SUM_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/cla_sum_pipe.sv
// cla_sum_pipe: two-stage pipelined carry-lookahead adder with valid/ready
// handshakes. Stage 1 registers bit and block propagate/generate terms,
// stage 2 resolves block carries by flattened lookahead and forms sum/cout.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cla_sum_pipe_if.slave (operands, result, both handshakes)
// Optional feature macro: CLA_SUM_OVF_EN adds the signed overflow output.
// in_ready is combinational from out_ready; all other outputs are registered.
module cla_sum_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLK   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    cla_sum_pipe_if.slave bus
);
    localparam int unsigned NBLK = WIDTH / BLK;

    if ((WIDTH % BLK) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_param_check
        $error("cla_sum_pipe: WIDTH must be 8..64 and a multiple of BLK");
    end

    logic             w_s1_en;
    logic             w_s2_en;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [NBLK-1:0]  w_bp;
    logic [NBLK-1:0]  w_bg;
    logic [NBLK:0]    w_bc;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_g;
    logic [NBLK-1:0]  r_bp;
    logic [NBLK-1:0]  r_bg;
    logic             r_cin;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef CLA_SUM_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
    logic             w_ovf;
`endif

    // Pipeline advance enables; a stage moves when the stage after it can take data.
    always_comb begin
        w_s2_en = !r_out_valid || bus.out_ready;
        w_s1_en = !r_s1_valid || w_s2_en;
    end

    // Stage 1: bit p/g and per-block group P/G (G built from the block bottom up).
    always_comb begin
        logic v_g;
        logic v_p;
        w_p  = bus.a ^ bus.b;
        w_g  = bus.a & bus.b;
        w_bp = '0;
        w_bg = '0;
        for (int k = 0; k < int'(NBLK); k++) begin
            v_g = 1'b0;
            v_p = 1'b1;
            for (int j = 0; j < int'(BLK); j++) begin
                v_g = w_g[k*int'(BLK)+j] | (w_p[k*int'(BLK)+j] & v_g);
                v_p = v_p & w_p[k*int'(BLK)+j];
            end
            w_bp[k] = v_p;
            w_bg[k] = v_g;
        end
    end

    // Stage 2: each block carry is a flat OR of G_j/cin terms gated by the P's above them.
    always_comb begin
        logic v_c;
        logic v_term;
        w_bc    = '0;
        w_bc[0] = r_cin;
        for (int k = 0; k < int'(NBLK); k++) begin
            v_c = r_cin;
            for (int m = 0; m <= k; m++) begin
                v_c = v_c & r_bp[m];
            end
            for (int j = 0; j <= k; j++) begin
                v_term = r_bg[j];
                for (int m = j + 1; m <= k; m++) begin
                    v_term = v_term & r_bp[m];
                end
                v_c = v_c | v_term;
            end
            w_bc[k+1] = v_c;
        end
        // Bit carries ripple only within a block, seeded by its lookahead carry.
        w_carry = '0;
        for (int k = 0; k < int'(NBLK); k++) begin
            v_c = w_bc[k];
            for (int j = 0; j < int'(BLK); j++) begin
                w_carry[k*int'(BLK)+j] = v_c;
                v_c = r_g[k*int'(BLK)+j] | (r_p[k*int'(BLK)+j] & v_c);
            end
        end
        w_sum = r_p ^ w_carry;
    end

`ifdef CLA_SUM_OVF_EN
    // Like-signed operands producing a differently signed result.
    assign w_ovf = (r_a_msb == r_b_msb) && (w_sum[WIDTH-1] != r_a_msb);
`endif

    // Pipeline registers; data moves only with valid data so bubbles never overwrite results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_p         <= '0;
            r_g         <= '0;
            r_bp        <= '0;
            r_bg        <= '0;
            r_cin       <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
`ifdef CLA_SUM_OVF_EN
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            if (w_s1_en) begin
                r_s1_valid <= bus.in_valid;
            end
            if (w_s1_en && bus.in_valid) begin
                r_p   <= w_p;
                r_g   <= w_g;
                r_bp  <= w_bp;
                r_bg  <= w_bg;
                r_cin <= bus.cin;
`ifdef CLA_SUM_OVF_EN
                r_a_msb <= bus.a[WIDTH-1];
                r_b_msb <= bus.b[WIDTH-1];
`endif
            end
            if (w_s2_en) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_s2_en && r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_bc[NBLK];
`ifdef CLA_SUM_OVF_EN
                r_ovf  <= w_ovf;
`endif
            end
        end
    end

    assign bus.in_ready  = w_s1_en;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
`ifdef CLA_SUM_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_cla_sum_pipe.sv
// tb_cla_sum_pipe: self-checking bench for cla_sum_pipe (WIDTH=16, BLK=4).
// Scoreboard of expected results from an arithmetic model; ovf checked when
// CLA_SUM_OVF_EN is defined.
module tb_cla_sum_pipe;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned BLK   = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_pushed = 0;
    int n_popped = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    cla_sum_pipe_if #(.WIDTH(WIDTH)) bus ();

    cla_sum_pipe #(.WIDTH(WIDTH), .BLK(BLK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int unsigned u;
        int          s;
        res_t        r;
        u      = 32'(a) + 32'(b) + 32'(cin);
        r.sum  = u[15:0];
        r.cout = u[16];
        s      = int'($signed(a)) + int'($signed(b)) + int'({31'd0, cin});
        r.ovf  = (s > 32767) || (s < -32768);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard both handshakes just before the edge, then advance one cycle.
    task automatic tick();
        res_t e;
        #1;
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got result %h with empty scoreboard", bus.sum);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sum", 32'(bus.sum), 32'(e.sum));
                    check("sb_cout", 32'(bus.cout), 32'(e.cout));
`ifdef CLA_SUM_OVF_EN
                    check("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                    n_popped++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.cin));
                n_pushed++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        bus.a   = 16'($urandom);
        bus.b   = 16'($urandom);
        bus.cin = 1'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        logic [15:0] held_sum;
        int base;

        vecs[0] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h7FFF, 16'h8000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

        // Reset held with in_valid asserted.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.a         = 16'hAAAA;
        bus.b         = 16'h5555;
        bus.cin       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_sum", 32'(bus.sum), 32'd0);
            check("rst_cout", 32'(bus.cout), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // First accepted operand: result visible after the next edge.
        bus.a = 16'h1234; bus.b = 16'h0001; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("lat_not_yet", 32'(bus.out_valid), 32'd0);
        tick();
        check("lat_valid", 32'(bus.out_valid), 32'd1);
        check("lat_sum", 32'(bus.sum), 32'h1235);
        tick();

        // Directed vectors, one at a time.
        for (int i = 0; i < 8; i++) begin
            bus.a = vecs[i].a; bus.b = vecs[i].b; bus.cin = vecs[i].cin;
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            tick();
            check("vec_valid", 32'(bus.out_valid), 32'd1);
            check($sformatf("vec%0d_sum", i), 32'(bus.sum), 32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 32'(bus.cout), 32'(vecs[i].exp_cout));
`ifdef CLA_SUM_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
`endif
            tick();
        end

        // Streaming at full rate.
        base = n_popped;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            rand_ops();
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("stream_count", 32'(n_popped - base), 32'd1000);
        check("stream_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: fill both stages, stall, release.
        base = n_pushed;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 10 && bus.in_ready; i++) begin
            rand_ops();
            tick();
        end
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_accepted", 32'(n_pushed - base), 32'd2);
        held_sum = bus.sum;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
            check("bp_hold_sum", 32'(bus.sum), 32'(held_sum));
            check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Random valid/ready over 2000 cycles.
        for (int i = 0; i < 2000; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            rand_ops();
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_balance", 32'(n_pushed), 32'(n_popped));

        // Reset mid-operation clears a full pipe asynchronously.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rand_ops();
        tick();
        rand_ops();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sum", 32'(bus.sum), 32'd0);
        check("midrst_cout", 32'(bus.cout), 32'd0);
        exp_q.delete();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.a = 16'h00FF; bus.b = 16'h0001; bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        check("post_rst_sum", 32'(bus.sum), 32'h0100);
        tick();
        check("post_rst_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
